// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_sync_fifo
// Purpose  : Single-clock synchronous FIFO with configurable width and depth,
//            programmable almost-full / almost-empty thresholds, defined
//            simultaneous read/write behaviour at full and empty, and an
//            optional first-word-fall-through (FWFT) read mode.
// Ports    : clk          - clock, all state changes on rising edge
//            reset        - synchronous active-high reset
//            wr_en        - write request
//            rd_en        - read request
//            d_in         - write data (DATA_W)
//            d_out        - read data (DATA_W), registered
//            full/empty   - occupancy == DEPTH / == 0
//            almost_full  - occupancy >= AF_LEVEL
//            almost_empty - occupancy <= AE_LEVEL
//            wr_ack/wr_err- previous-cycle write accepted / rejected
//            rd_ack/rd_err- previous-cycle read accepted / rejected
//            data_count   - current occupancy, 0..DEPTH (AW+1 bits)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module param_sync_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err,
  output logic [AW:0]       data_count
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (DATA_W < 1) begin : g_bad_width
      $error("param_sync_fifo: DATA_W must be >= 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (AW != $clog2(DEPTH)) begin : g_bad_aw
      $error("param_sync_fifo: AW is derived from DEPTH and must not be overridden");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_levels
      $error("param_sync_fifo: require 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  localparam logic [AW:0] c_depth    = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_af_level = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] c_ae_level = (AW+1)'(AE_LEVEL);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;
  logic [DATA_W-1:0] d_out_q,  d_out_d;
  logic              full_q, empty_q, almost_full_q, almost_empty_q;
  logic              wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;

  logic              rd_accept;
  logic              wr_accept;

  // --------------------------------------------------------------------------
  // Accept decisions and next-state pointers / occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    rd_accept = rd_en & ~empty_q;
    // A write at full is still taken when a read frees a slot in the same cycle.
    wr_accept = wr_en & (~full_q | rd_accept);

    wr_ptr_d = wr_accept ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = rd_accept ? (rd_ptr_q + AW'(1)) : rd_ptr_q;

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read-data next state
  // --------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // d_out tracks the post-edge head word. When the new head is the word
      // being written at this very edge (FIFO empty, or one entry popped while
      // writing) it is not in memory yet, so take it from d_in.
      always_comb begin
        d_out_d = d_out_q;
        if (count_d != '0) begin
          if (wr_accept && (rd_ptr_d == wr_ptr_q)) begin
            d_out_d = d_in;
          end else begin
            d_out_d = mem_q[rd_ptr_d];
          end
        end
      end
    end else begin : g_registered
      always_comb begin
        d_out_d = d_out_q;
        if (rd_accept) begin
          d_out_d = mem_q[rd_ptr_q];
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage array (not cleared by reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem_q[wr_ptr_q] <= d_in;
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      d_out_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      wr_ack_q       <= 1'b0;
      wr_err_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      rd_err_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      d_out_q        <= d_out_d;
      // Flags are registered from the post-edge occupancy.
      full_q         <= (count_d == c_depth);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= c_af_level);
      almost_empty_q <= (count_d <= c_ae_level);
      wr_ack_q       <= wr_accept;
      wr_err_q       <= wr_en & ~wr_accept;
      rd_ack_q       <= rd_accept;
      rd_err_q       <= rd_en & ~rd_accept;
    end
  end

  assign d_out        = d_out_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign rd_ack       = rd_ack_q;
  assign rd_err       = rd_err_q;
  assign data_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_sync_fifo
// Purpose  : Self-checking bench for param_sync_fifo. Instance A uses the
//            default configuration (32x8, registered read); instance B uses
//            16x4 with first-word-fall-through. A queue-based reference model
//            predicts every output after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=32, DEPTH=8, FWFT=0
  logic        rst_a = 1'b1, wr_a = 1'b0, rd_a = 1'b0;
  logic [31:0] din_a = '0, dout_a;
  logic        full_a, empty_a, af_a, ae_a, wack_a, werr_a, rack_a, rerr_a;
  logic [3:0]  cnt_a;

  // Instance B: DATA_W=16, DEPTH=4, FWFT=1
  logic        rst_b = 1'b1, wr_b = 1'b0, rd_b = 1'b0;
  logic [15:0] din_b = '0, dout_b;
  logic        full_b, empty_b, af_b, ae_b, wack_b, werr_b, rack_b, rerr_b;
  logic [2:0]  cnt_b;

  param_sync_fifo u_dut_a (
    .clk(clk), .reset(rst_a), .wr_en(wr_a), .rd_en(rd_a), .d_in(din_a),
    .d_out(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .wr_ack(wack_a), .wr_err(werr_a), .rd_ack(rack_a),
    .rd_err(rerr_a), .data_count(cnt_a)
  );

  param_sync_fifo #(.DATA_W(16), .DEPTH(4), .FWFT(1)) u_dut_b (
    .clk(clk), .reset(rst_b), .wr_en(wr_b), .rd_en(rd_b), .d_in(din_b),
    .d_out(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .wr_ack(wack_b), .wr_err(werr_b), .rd_ack(rack_b),
    .rd_err(rerr_b), .data_count(cnt_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_cyc  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cycle %0d: got=%h expected=%h", tag, n_cyc, got, exp);
    end
  endtask

  // Reference model state: stored words in arrival order plus expected d_out.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] ed_a = '0;
  logic [31:0] ed_b = '0;

  logic [31:0] e_dout;
  logic [3:0]  e_cnt;
  logic [3:0]  e_flags;   // {full, empty, almost_full, almost_empty}
  logic [3:0]  e_acks;    // {wr_ack, wr_err, rd_ack, rd_err}

  task automatic model(input int which, input bit rst, input bit wr, input bit rd,
                       input logic [31:0] din);
    logic [31:0] q[$];
    logic [31:0] ed;
    logic [31:0] popped;
    int          depth;
    bit          racc, wacc;
    depth = (which == 0) ? 8 : 4;
    if (which == 0) begin q = qa; ed = ed_a; end
    else begin q = qb; ed = ed_b; end
    popped = '0;
    if (rst) begin
      q.delete();
      ed     = '0;
      e_acks = 4'b0000;
    end else begin
      racc = rd && (q.size() > 0);
      wacc = wr && ((q.size() < depth) || racc);
      if (racc) popped = q.pop_front();
      if (wacc) q.push_back(din);
      if (which == 0) begin
        if (racc) ed = popped;
      end else begin
        if (q.size() > 0) ed = q[0];
      end
      e_acks = {wacc, wr && !wacc, racc, rd && !racc};
    end
    e_dout  = ed;
    e_cnt   = 4'(q.size());
    e_flags = {q.size() == depth, q.size() == 0, q.size() >= depth - 1, q.size() <= 1};
    if (which == 0) begin qa = q; ed_a = ed; end
    else begin qb = q; ed_b = ed; end
  endtask

  // One clock cycle on the selected instance, followed by a full output check.
  task automatic cyc(input int which, input bit rst, input bit wr, input bit rd,
                     input logic [31:0] din);
    logic [31:0] d;
    string       p;
    d = (which == 0) ? din : (din & 32'h0000_FFFF);
    if (which == 0) begin
      rst_a = rst; wr_a = wr; rd_a = rd; din_a = d;
    end else begin
      rst_b = rst; wr_b = wr; rd_b = rd; din_b = d[15:0];
    end
    @(posedge clk);
    n_cyc++;
    model(which, rst, wr, rd, d);
    #1;
    p = (which == 0) ? "A" : "B";
    if (which == 0) begin
      chk({p, ".d_out"}, 64'(dout_a), 64'(e_dout));
      chk({p, ".data_count"}, 64'(cnt_a), 64'(e_cnt));
      chk({p, ".flags"}, 64'({full_a, empty_a, af_a, ae_a}), 64'(e_flags));
      chk({p, ".ack_err"}, 64'({wack_a, werr_a, rack_a, rerr_a}), 64'(e_acks));
    end else begin
      chk({p, ".d_out"}, 64'(dout_b), 64'(e_dout));
      chk({p, ".data_count"}, 64'(cnt_b), 64'(e_cnt));
      chk({p, ".flags"}, 64'({full_b, empty_b, af_b, ae_b}), 64'(e_flags));
      chk({p, ".ack_err"}, 64'({wack_b, werr_b, rack_b, rerr_b}), 64'(e_acks));
    end
  endtask

  task automatic random_phase(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(which, ($urandom_range(63) == 0), ($urandom_range(99) < 60),
          ($urandom_range(99) < 50), $urandom);
    end
  endtask

  initial begin
    // ---------------- Instance A: 32x8, registered read ----------------
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 1, 1, 1, 32'hDEAD_BEEF);              // reset wins over wr/rd
    for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 0, 32'h1111_1111 * i);
    cyc(0, 0, 1, 0, 32'h9999_9999);              // write at full rejected
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 32'h0);  // drain, 9th rejected
    for (int i = 1; i <= 8; i++) cyc(0, 0, 1, 0, 32'h1111_1111 * i);
    cyc(0, 0, 1, 1, 32'hAAAA_AAAA);              // simultaneous at full
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 1, 1, 32'h1234_5678);              // simultaneous at empty
    cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    random_phase(0, 400);
    rst_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0;

    // ---------------- Instance B: 16x4, FWFT ----------------
    cyc(1, 1, 0, 0, 32'h0);
    cyc(1, 0, 1, 0, 32'h0000_BEEF);              // BEEF visible without rd_en
    cyc(1, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 1, 32'h0);                      // pop, d_out holds
    cyc(1, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 1, 32'h0);                      // read on empty
    for (int i = 1; i <= 3; i++) cyc(1, 0, 1, 0, 32'h0000_1000 * i);
    cyc(1, 1, 0, 0, 32'h0);                      // reset at count 3
    cyc(1, 0, 0, 0, 32'h0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 1, 0, 32'h0000_00A0 + i);
    cyc(1, 0, 1, 1, 32'h0000_5555);              // simultaneous at full
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 32'h0);
    random_phase(1, 400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
